reorder_buffer: RTL and testbench
=================================

Name: reorder_buffer

Overview:
- Circular in-order retirement buffer that allocates the rename tags the register file records at issue.
- Captures results from the common data bus (CDB).
- Retires entries in program order, driving the register file's commit port.
- Detects branch mispredictions at retirement and raises a rollback.

Parameters:
- ROB_SIZE, 16, number of entries, power of two.
- ROB_POS_W, 4, log2(ROB_SIZE); width of a ROB position.
- DATA_W, 32, data and PC width.
- REG_W, 5, architectural register index width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- rdy  in  1  global enable; when 0 all state holds.
- issue  in  1  decoder issues one instruction this cycle.
- issue_rd  in  REG_W  destination register; 0 = none.
- issue_type  in  2  0=reg-write, 1=branch, 2=store, 3=jalr.
- issue_pred_jump  in  1  predicted taken.
- issue_pc  in  DATA_W  instruction PC; rollback target base.
- issue_rob_pos  out  ROB_POS_W  tail position that the next issue occupies.
- rob_full  out  1  count == ROB_SIZE (combinational).
- cdb_valid  in  1  result writeback.
- cdb_rob_pos  in  ROB_POS_W  entry completed.
- cdb_val  in  DATA_W  rd value.
- cdb_jump  in  1  actual taken (branch/jalr).
- cdb_target  in  DATA_W  actual target when taken.
- q1_pos  in  ROB_POS_W  operand query position.
- q1_ready  out  1  queried result available.
- q1_val  out  DATA_W  queried result.
- q2_pos, q2_ready, q2_val: same as q1.
- commit  out  1  one-cycle retire pulse, registered.
- commit_rd  out  REG_W  retired rd; 0 for branch/store.
- commit_val  out  DATA_W  retired value.
- commit_rob_pos  out  ROB_POS_W  retired position.
- commit_store  out  1  pulse with commit when the retired entry is a store.
- rollback  out  1  one-cycle misprediction pulse, registered.
- rollback_pc  out  DATA_W  correct next PC.

Behaviour:
- Reset (async, rst_n=0):
  - head=tail=count=0; all entry ready bits cleared.
  - commit, commit_store, rollback = 0; commit_rd/val/rob_pos = 0; rollback_pc = 0.
- Entry fields: busy, ready, rd, type, pred_jump, pc, val, jump, target.
- Issue (rdy, issue, !rob_full, !rollback):
  - Writes entry[tail] with ready=0; tail wraps modulo ROB_SIZE.
  - issue_rob_pos = tail.
  - Issue while full or during the rollback cycle is ignored; the bench flags it as a protocol error.
- Writeback (rdy, cdb_valid): sets entry[cdb_rob_pos] ready=1 and latches val, jump, target. A CDB write to a non-busy entry is ignored.
- Retire:
  - Condition: rdy, count>0, entry[head].ready, !rollback.
  - Registered outputs next cycle: commit=1, commit_rd (forced 0 if type is branch/store), commit_val, commit_rob_pos=head, commit_store.
  - head increments and wraps; busy is cleared.
  - At most one retire per cycle.
  - A writeback to head is not retired in the same cycle; it retires one cycle later.
- Misprediction:
  - Applies when the retiring entry is a branch with jump != pred_jump, or any jalr.
  - rollback=1 next cycle.
  - rollback_pc = target if jump, else pc+4, with DATA_W wrap.
  - The commit pulse is still issued for that entry, since a jalr writes rd.
  - At the same edge all entries are cleared and head=tail=count=0.
- Count: count_next = count + issue_accepted - retire. Simultaneous issue and retire at count==ROB_SIZE: the issue is rejected because rob_full samples pre-edge count.
- Query (combinational):
  - q_ready = entry[q_pos].ready, or (cdb_valid && cdb_rob_pos==q_pos).
  - q_val comes from the CDB on bypass, otherwise from the entry.
- rdy=0 freezes all state. Pulse outputs deassert after one active cycle.

Decomposition:
- Shared macros package:
  - ROB_SIZE, ROB_POS_W, DATA_W, REG_W.
  - ROB_ID_W = ROB_POS_W+1, the {renamed flag, pos} format used by the register file.
  - issue_type encodings.
- One natural sub-module, rob_entry_array: an entry storage array with two combinational query ports plus a CDB bypass.

Test Plan:
- Reset, then issue rd=5 type0 (pos0); CDB pos0 val=0x1234 -> one cycle later commit=1, commit_rd=5, commit_val=0x1234, commit_rob_pos=0.
- Issue 16 entries -> rob_full=1 and a 17th issue is ignored. CDB writes pos3 then pos0 -> only pos0 retires; pos3 waits for pos1 and pos2, then retires in order.
- Branch pc=0x100, pred_jump=0, CDB jump=1 target=0x200 -> rollback=1, rollback_pc=0x200, commit_rd=0; next cycle count=0, issue_rob_pos=0.
- Branch pc=0x1000, pred_jump=1, jump=0 -> rollback_pc=0x1004. A correctly predicted branch -> no rollback.
- Query q1_pos=2 while cdb_valid with pos2 val=0xAB -> q1_ready=1, q1_val=0xAB in the same cycle.
- Fill to full with tail wrap at pos 15 to 0; assert rst_n low mid-stream -> all outputs 0 immediately.

Source files
------------

// File: rtl/reorder_buffer_pkg.sv
// Shared widths, entry layout and small helpers for the reorder buffer.
package reorder_buffer_pkg;

    localparam int unsigned ROB_SIZE  = 16;
    localparam int unsigned ROB_POS_W = 4;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned REG_W     = 5;

    // Register-file tag format: {renamed flag, rob position}.
    localparam int unsigned ROB_ID_W  = ROB_POS_W + 1;

    // Occupancy counter needs one extra bit to represent a full buffer.
    localparam int unsigned ROB_CNT_W = ROB_POS_W + 1;

    typedef logic [ROB_ID_W-1:0] rob_id_t;

    typedef enum logic [1:0] {
        TypeReg    = 2'd0,
        TypeBranch = 2'd1,
        TypeStore  = 2'd2,
        TypeJalr   = 2'd3
    } issue_type_e;

    typedef struct packed {
        logic              busy;
        logic              ready;
        logic [REG_W-1:0]  rd;
        issue_type_e       itype;
        logic              pred_jump;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] val;
        logic              jump;
        logic [DATA_W-1:0] target;
    } rob_entry_t;

    // A jalr target is never predicted, so every jalr redirects the front end.
    function automatic logic is_mispredict(input rob_entry_t e);
        return ((e.itype == TypeBranch) && (e.jump != e.pred_jump)) || (e.itype == TypeJalr);
    endfunction

    // Correct next PC for a redirected instruction; pc+4 wraps at DATA_W.
    function automatic logic [DATA_W-1:0] redirect_pc(input rob_entry_t e);
        return e.jump ? e.target : (e.pc + DATA_W'(4));
    endfunction

    // Branches and stores have no destination register.
    function automatic logic writes_rd(input issue_type_e t);
        return (t == TypeReg) || (t == TypeJalr);
    endfunction

endpackage

// File: rtl/reorder_buffer_entries.sv
// Entry storage for the reorder buffer: allocation, CDB capture, head release,
// bulk flush and two combinational operand query ports with CDB bypass.
module reorder_buffer_entries
    import reorder_buffer_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 alloc,
    input  logic [ROB_POS_W-1:0] alloc_pos,
    input  logic [REG_W-1:0]     alloc_rd,
    input  issue_type_e          alloc_type,
    input  logic                 alloc_pred_jump,
    input  logic [DATA_W-1:0]    alloc_pc,
    input  logic                 wb,
    input  logic                 cdb_valid,
    input  logic [ROB_POS_W-1:0] cdb_rob_pos,
    input  logic [DATA_W-1:0]    cdb_val,
    input  logic                 cdb_jump,
    input  logic [DATA_W-1:0]    cdb_target,
    input  logic                 free_head,
    input  logic [ROB_POS_W-1:0] head_pos,
    output rob_entry_t           head_entry,
    input  logic [ROB_POS_W-1:0] q1_pos,
    output logic                 q1_ready,
    output logic [DATA_W-1:0]    q1_val,
    input  logic [ROB_POS_W-1:0] q2_pos,
    output logic                 q2_ready,
    output logic [DATA_W-1:0]    q2_val
);

    rob_entry_t entries [ROB_SIZE];

    // Entry updates: flush beats everything; CDB writes only land on busy entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(ROB_SIZE); i++) begin
                entries[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < int'(ROB_SIZE); i++) begin
                entries[i].busy  <= 1'b0;
                entries[i].ready <= 1'b0;
            end
        end else begin
            for (int i = 0; i < int'(ROB_SIZE); i++) begin
                if (alloc && (alloc_pos == ROB_POS_W'(i))) begin
                    entries[i].busy      <= 1'b1;
                    entries[i].ready     <= 1'b0;
                    entries[i].rd        <= alloc_rd;
                    entries[i].itype     <= alloc_type;
                    entries[i].pred_jump <= alloc_pred_jump;
                    entries[i].pc        <= alloc_pc;
                end
                if (wb && entries[i].busy && (cdb_rob_pos == ROB_POS_W'(i))) begin
                    entries[i].ready  <= 1'b1;
                    entries[i].val    <= cdb_val;
                    entries[i].jump   <= cdb_jump;
                    entries[i].target <= cdb_target;
                end
                if (free_head && (head_pos == ROB_POS_W'(i))) begin
                    entries[i].busy <= 1'b0;
                end
            end
        end
    end

    assign head_entry = entries[head_pos];

    // Query port 1: a result on the CDB this cycle is forwarded directly.
    always_comb begin
        q1_ready = entries[q1_pos].ready;
        q1_val   = entries[q1_pos].val;
        if (cdb_valid && (cdb_rob_pos == q1_pos)) begin
            q1_ready = 1'b1;
            q1_val   = cdb_val;
        end
    end

    // Query port 2: same forwarding rule as port 1.
    always_comb begin
        q2_ready = entries[q2_pos].ready;
        q2_val   = entries[q2_pos].val;
        if (cdb_valid && (cdb_rob_pos == q2_pos)) begin
            q2_ready = 1'b1;
            q2_val   = cdb_val;
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// Circular in-order retirement buffer: allocates tags at issue, captures CDB
// results, retires in program order and raises rollback on misprediction.
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rdy,
    input  logic                 issue,
    input  logic [REG_W-1:0]     issue_rd,
    input  logic [1:0]           issue_type,
    input  logic                 issue_pred_jump,
    input  logic [DATA_W-1:0]    issue_pc,
    output logic [ROB_POS_W-1:0] issue_rob_pos,
    output logic                 rob_full,
    input  logic                 cdb_valid,
    input  logic [ROB_POS_W-1:0] cdb_rob_pos,
    input  logic [DATA_W-1:0]    cdb_val,
    input  logic                 cdb_jump,
    input  logic [DATA_W-1:0]    cdb_target,
    input  logic [ROB_POS_W-1:0] q1_pos,
    output logic                 q1_ready,
    output logic [DATA_W-1:0]    q1_val,
    input  logic [ROB_POS_W-1:0] q2_pos,
    output logic                 q2_ready,
    output logic [DATA_W-1:0]    q2_val,
    output logic                 commit,
    output logic [REG_W-1:0]     commit_rd,
    output logic [DATA_W-1:0]    commit_val,
    output logic [ROB_POS_W-1:0] commit_rob_pos,
    output logic                 commit_store,
    output logic                 rollback,
    output logic [DATA_W-1:0]    rollback_pc
);

    logic [ROB_POS_W-1:0] head;
    logic [ROB_POS_W-1:0] tail;
    logic [ROB_CNT_W-1:0] count;
    rob_entry_t           head_entry;
    logic                 issue_ok;
    logic                 retire;
    logic                 mispredict;
    logic                 wb;

    assign rob_full      = (count == ROB_CNT_W'(ROB_SIZE));
    assign issue_rob_pos = tail;

    // The rollback cycle blocks both issue and retire: the front end is being
    // redirected and the buffer was just emptied.
    assign issue_ok   = rdy & issue & ~rob_full & ~rollback;
    assign retire     = rdy & (count != '0) & head_entry.ready & ~rollback;
    assign mispredict = retire & is_mispredict(head_entry);
    assign wb         = rdy & cdb_valid;

    reorder_buffer_entries u_entries (
        .clk             (clk),
        .rst_n           (rst_n),
        .flush           (mispredict),
        .alloc           (issue_ok),
        .alloc_pos       (tail),
        .alloc_rd        (issue_rd),
        .alloc_type      (issue_type_e'(issue_type)),
        .alloc_pred_jump (issue_pred_jump),
        .alloc_pc        (issue_pc),
        .wb              (wb),
        .cdb_valid       (cdb_valid),
        .cdb_rob_pos     (cdb_rob_pos),
        .cdb_val         (cdb_val),
        .cdb_jump        (cdb_jump),
        .cdb_target      (cdb_target),
        .free_head       (retire),
        .head_pos        (head),
        .head_entry      (head_entry),
        .q1_pos          (q1_pos),
        .q1_ready        (q1_ready),
        .q1_val          (q1_val),
        .q2_pos          (q2_pos),
        .q2_ready        (q2_ready),
        .q2_val          (q2_val)
    );

    // Head/tail/count bookkeeping; a misprediction empties the buffer outright.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (rdy) begin
            if (mispredict) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (retire) begin
                    head <= head + 1'b1;
                end
                if (issue_ok) begin
                    tail <= tail + 1'b1;
                end
                count <= count + ROB_CNT_W'(issue_ok) - ROB_CNT_W'(retire);
            end
        end
    end

    // Registered retire and rollback outputs; data fields hold between pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            commit         <= 1'b0;
            commit_store   <= 1'b0;
            commit_rd      <= '0;
            commit_val     <= '0;
            commit_rob_pos <= '0;
            rollback       <= 1'b0;
            rollback_pc    <= '0;
        end else if (rdy) begin
            commit       <= retire;
            commit_store <= retire & (head_entry.itype == TypeStore);
            rollback     <= mispredict;
            if (retire) begin
                commit_rd      <= writes_rd(head_entry.itype) ? head_entry.rd : '0;
                commit_val     <= head_entry.val;
                commit_rob_pos <= head;
            end
            if (mispredict) begin
                rollback_pc <= redirect_pc(head_entry);
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios plus a random
// phase, all compared against a queue-based program-order model.
module tb_reorder_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rdy;
    logic        issue;
    logic [4:0]  issue_rd;
    logic [1:0]  issue_type;
    logic        issue_pred_jump;
    logic [31:0] issue_pc;
    logic [3:0]  issue_rob_pos;
    logic        rob_full;
    logic        cdb_valid;
    logic [3:0]  cdb_rob_pos;
    logic [31:0] cdb_val;
    logic        cdb_jump;
    logic [31:0] cdb_target;
    logic [3:0]  q1_pos;
    logic        q1_ready;
    logic [31:0] q1_val;
    logic [3:0]  q2_pos;
    logic        q2_ready;
    logic [31:0] q2_val;
    logic        commit;
    logic [4:0]  commit_rd;
    logic [31:0] commit_val;
    logic [3:0]  commit_rob_pos;
    logic        commit_store;
    logic        rollback;
    logic [31:0] rollback_pc;

    reorder_buffer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rdy             (rdy),
        .issue           (issue),
        .issue_rd        (issue_rd),
        .issue_type      (issue_type),
        .issue_pred_jump (issue_pred_jump),
        .issue_pc        (issue_pc),
        .issue_rob_pos   (issue_rob_pos),
        .rob_full        (rob_full),
        .cdb_valid       (cdb_valid),
        .cdb_rob_pos     (cdb_rob_pos),
        .cdb_val         (cdb_val),
        .cdb_jump        (cdb_jump),
        .cdb_target      (cdb_target),
        .q1_pos          (q1_pos),
        .q1_ready        (q1_ready),
        .q1_val          (q1_val),
        .q2_pos          (q2_pos),
        .q2_ready        (q2_ready),
        .q2_val          (q2_val),
        .commit          (commit),
        .commit_rd       (commit_rd),
        .commit_val      (commit_val),
        .commit_rob_pos  (commit_rob_pos),
        .commit_store    (commit_store),
        .rollback        (rollback),
        .rollback_pc     (rollback_pc)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail = 0;
    int n_ignored = 0;

    // Model: in-flight instructions in program order.
    typedef struct {
        int          pos;
        logic [4:0]  rd;
        logic [1:0]  typ;
        logic        pred;
        logic [31:0] pc;
        logic        done;
        logic [31:0] val;
        logic        jump;
        logic [31:0] target;
    } ment_t;

    ment_t       mq[$];
    int          m_tail;
    logic        m_commit, m_cstore, m_rb;
    logic [4:0]  m_crd;
    logic [31:0] m_cval, m_rbpc;
    int          m_cpos;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_tail = 0;
        m_commit = 0; m_cstore = 0; m_rb = 0;
        m_crd = 0; m_cval = 0; m_rbpc = 0; m_cpos = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        bit    iss_ok, ret, mis;
        ment_t h, e;
        if (!rdy) return;
        iss_ok = issue && (mq.size() < 16) && !m_rb;
        if (issue && !iss_ok) n_ignored++;
        ret = (mq.size() > 0) && mq[0].done && !m_rb;
        if (ret) h = mq[0];
        mis = ret && ((h.typ == 2'd1 && h.jump != h.pred) || h.typ == 2'd3);
        if (cdb_valid) begin
            foreach (mq[i]) begin
                if (mq[i].pos == int'(cdb_rob_pos)) begin
                    e = mq[i];
                    e.done = 1; e.val = cdb_val; e.jump = cdb_jump; e.target = cdb_target;
                    mq[i] = e;
                end
            end
        end
        m_commit = ret;
        m_cstore = ret && (h.typ == 2'd2);
        m_rb = mis;
        if (ret) begin
            m_crd = (h.typ == 2'd1 || h.typ == 2'd2) ? 5'd0 : h.rd;
            m_cval = h.val;
            m_cpos = h.pos;
            void'(mq.pop_front());
        end
        if (mis) m_rbpc = h.jump ? h.target : h.pc + 32'd4;
        if (iss_ok) begin
            e.pos = m_tail; e.rd = issue_rd; e.typ = issue_type; e.pred = issue_pred_jump;
            e.pc = issue_pc; e.done = 0; e.val = 0; e.jump = 0; e.target = 0;
            mq.push_back(e);
            m_tail = (m_tail + 1) % 16;
        end
        if (mis) begin
            mq.delete();
            m_tail = 0;
        end
    endtask

    task automatic query_expect(input logic [3:0] pos, output bit known, output logic rv,
                                output logic [31:0] v);
        known = 0; rv = 0; v = 0;
        if (cdb_valid && cdb_rob_pos == pos) begin
            known = 1; rv = 1; v = cdb_val;
            return;
        end
        foreach (mq[i]) begin
            if (mq[i].pos == int'(pos)) begin
                known = 1; rv = mq[i].done; v = mq[i].val;
            end
        end
    endtask

    task automatic check_comb();
        bit          k;
        logic        r;
        logic [31:0] v;
        chk("rob_full", 32'(rob_full), 32'(mq.size() == 16));
        chk("issue_rob_pos", 32'(issue_rob_pos), 32'(m_tail));
        query_expect(q1_pos, k, r, v);
        if (k) begin
            chk("q1_ready", 32'(q1_ready), 32'(r));
            if (r) chk("q1_val", q1_val, v);
        end
        query_expect(q2_pos, k, r, v);
        if (k) begin
            chk("q2_ready", 32'(q2_ready), 32'(r));
            if (r) chk("q2_val", q2_val, v);
        end
    endtask

    task automatic check_regs();
        chk("commit", 32'(commit), 32'(m_commit));
        chk("commit_store", 32'(commit_store), 32'(m_cstore));
        chk("rollback", 32'(rollback), 32'(m_rb));
        if (m_commit) begin
            chk("commit_rd", 32'(commit_rd), 32'(m_crd));
            chk("commit_val", commit_val, m_cval);
            chk("commit_rob_pos", 32'(commit_rob_pos), 32'(m_cpos));
        end
        if (m_rb) chk("rollback_pc", rollback_pc, m_rbpc);
        chk("post_rob_full", 32'(rob_full), 32'(mq.size() == 16));
        chk("post_issue_rob_pos", 32'(issue_rob_pos), 32'(m_tail));
    endtask

    // One clock: inputs were set just after the previous posedge.
    task automatic cycle();
        #2;
        check_comb();
        model_step();
        @(posedge clk);
        #1;
        check_regs();
    endtask

    task automatic idle_inputs();
        rdy = 1; issue = 0; issue_rd = 0; issue_type = 0; issue_pred_jump = 0; issue_pc = 0;
        cdb_valid = 0; cdb_rob_pos = 0; cdb_val = 0; cdb_jump = 0; cdb_target = 0;
    endtask

    task automatic set_issue(input logic [4:0] rd, input logic [1:0] t, input logic p,
                             input logic [31:0] pc);
        idle_inputs();
        issue = 1; issue_rd = rd; issue_type = t; issue_pred_jump = p; issue_pc = pc;
    endtask

    task automatic set_cdb(input logic [3:0] pos, input logic [31:0] v, input logic j,
                           input logic [31:0] tgt);
        idle_inputs();
        cdb_valid = 1; cdb_rob_pos = pos; cdb_val = v; cdb_jump = j; cdb_target = tgt;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1;
        model_reset();
    endtask

    int order[$];
    int pend[$];

    initial begin
        rst_n = 0;
        q1_pos = 0;
        q2_pos = 0;
        idle_inputs();
        model_reset();

        // Reset state and a single reg-write round trip.
        do_reset();
        chk("rst_commit", 32'(commit), 32'd0);
        chk("rst_rollback", 32'(rollback), 32'd0);
        chk("rst_rollback_pc", rollback_pc, 32'd0);
        chk("rst_commit_val", commit_val, 32'd0);
        chk("rst_issue_rob_pos", 32'(issue_rob_pos), 32'd0);
        set_issue(5'd5, 2'd0, 1'b0, 32'h0);
        cycle();
        set_cdb(4'd0, 32'h1234, 1'b0, 32'h0);
        cycle();
        idle_inputs();
        cycle();
        chk("t1_commit", 32'(commit), 32'd1);
        chk("t1_commit_rd", 32'(commit_rd), 32'd5);
        chk("t1_commit_val", commit_val, 32'h1234);
        chk("t1_commit_pos", 32'(commit_rob_pos), 32'd0);

        // Fill to full, reject a 17th issue, then out-of-order completion.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            set_issue(5'(i + 1), 2'd0, 1'b0, 32'h400 + 32'(4 * i));
            cycle();
        end
        idle_inputs();
        #1;
        chk("t2_full", 32'(rob_full), 32'd1);
        set_issue(5'd31, 2'd0, 1'b0, 32'h999);
        cycle();
        chk("t2_still_full", 32'(rob_full), 32'd1);
        chk("t2_tail_kept", 32'(issue_rob_pos), 32'd0);
        set_cdb(4'd3, 32'h33, 1'b0, 32'h0);
        cycle();
        set_cdb(4'd0, 32'h300, 1'b0, 32'h0);
        cycle();
        idle_inputs();
        cycle();
        chk("t2_commit0", 32'(commit), 32'd1);
        chk("t2_commit0_pos", 32'(commit_rob_pos), 32'd0);
        chk("t2_commit0_rd", 32'(commit_rd), 32'd1);
        cycle();
        chk("t2_pos3_waits", 32'(commit), 32'd0);
        chk("t2_not_full", 32'(rob_full), 32'd0);
        order.delete();
        set_cdb(4'd1, 32'h11, 1'b0, 32'h0);
        cycle();
        if (commit) order.push_back(int'(commit_rob_pos));
        set_cdb(4'd2, 32'h22, 1'b0, 32'h0);
        cycle();
        if (commit) order.push_back(int'(commit_rob_pos));
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            cycle();
            if (commit) order.push_back(int'(commit_rob_pos));
        end
        chk("t2_order_len", 32'(order.size()), 32'd3);
        if (order.size() == 3) begin
            chk("t2_order0", 32'(order[0]), 32'd1);
            chk("t2_order1", 32'(order[1]), 32'd2);
            chk("t2_order2", 32'(order[2]), 32'd3);
        end

        // Not-taken-predicted branch that is taken: rollback to target, flush.
        do_reset();
        set_issue(5'd7, 2'd1, 1'b0, 32'h100);
        cycle();
        set_issue(5'd9, 2'd0, 1'b0, 32'h104);
        cycle();
        set_cdb(4'd0, 32'h0, 1'b1, 32'h200);
        cycle();
        idle_inputs();
        cycle();
        chk("t3_rollback", 32'(rollback), 32'd1);
        chk("t3_rollback_pc", rollback_pc, 32'h200);
        chk("t3_commit", 32'(commit), 32'd1);
        chk("t3_commit_rd", 32'(commit_rd), 32'd0);
        chk("t3_tail_zero", 32'(issue_rob_pos), 32'd0);
        set_issue(5'd3, 2'd0, 1'b0, 32'h200);
        cycle();
        chk("t3_rb_issue_ignored", 32'(issue_rob_pos), 32'd0);
        chk("t3_rb_pulse_done", 32'(rollback), 32'd0);
        set_issue(5'd3, 2'd0, 1'b0, 32'h200);
        cycle();
        chk("t3_issue_after", 32'(issue_rob_pos), 32'd1);
        set_cdb(4'd1, 32'h77, 1'b0, 32'h0);
        cycle();
        set_cdb(4'd0, 32'h55, 1'b0, 32'h0);
        cycle();
        idle_inputs();
        cycle();
        chk("t3_new_commit_rd", 32'(commit_rd), 32'd3);
        chk("t3_new_commit_val", commit_val, 32'h55);

        // Taken-predicted branch falls through; correct prediction; store; jalr.
        do_reset();
        set_issue(5'd0, 2'd1, 1'b1, 32'h1000);
        cycle();
        set_cdb(4'd0, 32'h0, 1'b0, 32'hdead);
        cycle();
        idle_inputs();
        cycle();
        chk("t4_rollback", 32'(rollback), 32'd1);
        chk("t4_rollback_pc", rollback_pc, 32'h1004);
        cycle();
        set_issue(5'd0, 2'd1, 1'b1, 32'h2000);
        cycle();
        set_cdb(4'd0, 32'h0, 1'b1, 32'h3000);
        cycle();
        idle_inputs();
        cycle();
        chk("t4_good_commit", 32'(commit), 32'd1);
        chk("t4_good_no_rb", 32'(rollback), 32'd0);
        set_issue(5'd4, 2'd2, 1'b0, 32'h2004);
        cycle();
        set_cdb(4'd1, 32'h8, 1'b0, 32'h0);
        cycle();
        idle_inputs();
        cycle();
        chk("t4_store", 32'(commit_store), 32'd1);
        chk("t4_store_rd", 32'(commit_rd), 32'd0);
        set_issue(5'd1, 2'd3, 1'b0, 32'h40);
        cycle();
        set_cdb(4'd2, 32'h44, 1'b1, 32'h80);
        cycle();
        idle_inputs();
        cycle();
        chk("t4_jalr_rb", 32'(rollback), 32'd1);
        chk("t4_jalr_pc", rollback_pc, 32'h80);
        chk("t4_jalr_rd", 32'(commit_rd), 32'd1);
        chk("t4_jalr_val", commit_val, 32'h44);
        cycle();
        set_issue(5'd0, 2'd1, 1'b1, 32'hFFFF_FFFC);
        cycle();
        set_cdb(4'd0, 32'h0, 1'b0, 32'h0);
        cycle();
        idle_inputs();
        cycle();
        chk("t4_pc_wrap", rollback_pc, 32'h0);

        // Same-cycle CDB bypass on the query port.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_issue(5'(i + 10), 2'd0, 1'b0, 32'h500);
            cycle();
        end
        q1_pos = 4'd2;
        q2_pos = 4'd1;
        set_cdb(4'd2, 32'hAB, 1'b0, 32'h0);
        #1;
        chk("t5_bypass_ready", 32'(q1_ready), 32'd1);
        chk("t5_bypass_val", q1_val, 32'hAB);
        chk("t5_q2_not_ready", 32'(q2_ready), 32'd0);
        cycle();
        idle_inputs();
        #1;
        chk("t5_stored_ready", 32'(q1_ready), 32'd1);
        chk("t5_stored_val", q1_val, 32'hAB);
        cycle();

        // Random traffic, heavy issue first so the buffer fills and wraps.
        do_reset();
        for (int n = 0; n < 800; n++) begin
            int ib, cb, t;
            ib = (n < 400) ? 8 : 5;
            cb = (n < 400) ? 3 : 6;
            idle_inputs();
            rdy = ($urandom_range(0, 9) != 0);
            issue = ($urandom_range(0, 9) < ib);
            t = $urandom_range(0, 19);
            issue_type = (t < 12) ? 2'd0 : (t < 16) ? 2'd1 : (t < 19) ? 2'd2 : 2'd3;
            issue_rd = 5'($urandom_range(0, 31));
            issue_pred_jump = 1'($urandom_range(0, 1));
            issue_pc = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            pend.delete();
            foreach (mq[i]) if (!mq[i].done) pend.push_back(mq[i].pos);
            cdb_valid = ($urandom_range(0, 9) < cb);
            if (pend.size() > 0 && $urandom_range(0, 9) != 0)
                cdb_rob_pos = 4'(pend[$urandom_range(0, pend.size() - 1)]);
            else
                cdb_rob_pos = 4'($urandom_range(0, 15));
            cdb_val = $urandom;
            cdb_target = $urandom;
            cdb_jump = 1'($urandom_range(0, 1));
            foreach (mq[i]) begin
                if (mq[i].pos == int'(cdb_rob_pos) && $urandom_range(0, 4) != 0)
                    cdb_jump = mq[i].pred;
            end
            q1_pos = 4'($urandom_range(0, 15));
            q2_pos = ($urandom_range(0, 1) == 1) ? cdb_rob_pos : 4'($urandom_range(0, 15));
            cycle();
        end

        // Tail wrap 15 -> 0, then asynchronous reset mid-stream.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            set_issue(5'(i), 2'd0, 1'b0, 32'h600);
            cycle();
        end
        for (int i = 0; i < 10; i++) begin
            set_cdb(4'(i), 32'(i), 1'b0, 32'h0);
            cycle();
        end
        idle_inputs();
        for (int i = 0; i < 3; i++) cycle();
        for (int i = 0; i < 16; i++) begin
            set_issue(5'(i + 1), 2'd0, 1'b0, 32'h700);
            cycle();
            if (i == 5) chk("t7_wrap_to_zero", 32'(issue_rob_pos), 32'd0);
        end
        chk("t7_full", 32'(rob_full), 32'd1);
        chk("t7_tail", 32'(issue_rob_pos), 32'd10);
        set_cdb(4'd10, 32'hCAFE, 1'b0, 32'h0);
        cycle();
        idle_inputs();
        cycle();
        chk("t7_commit10", 32'(commit), 32'd1);
        chk("t7_commit10_pos", 32'(commit_rob_pos), 32'd10);
        #2;
        rst_n = 0;
        #1;
        model_reset();
        chk("t7_rst_commit", 32'(commit), 32'd0);
        chk("t7_rst_commit_rd", 32'(commit_rd), 32'd0);
        chk("t7_rst_commit_val", commit_val, 32'd0);
        chk("t7_rst_commit_pos", 32'(commit_rob_pos), 32'd0);
        chk("t7_rst_store", 32'(commit_store), 32'd0);
        chk("t7_rst_rollback", 32'(rollback), 32'd0);
        chk("t7_rst_rollback_pc", rollback_pc, 32'd0);
        chk("t7_rst_full", 32'(rob_full), 32'd0);
        chk("t7_rst_tail", 32'(issue_rob_pos), 32'd0);
        q1_pos = 4'd11;
        #1;
        chk("t7_rst_q1_ready", 32'(q1_ready), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1;
        for (int i = 0; i < 3; i++) cycle();

        $display("[TB] note: %0d issue attempts ignored while full or in rollback", n_ignored);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
